sddr_init_seq: RTL and testbench
================================

// Module: sddr_init_seq
// PURPOSE
//  DDR3 power-up/initialisation sequencer. Sits directly upstream of sddr_phy_xilinx in the in_ddr_clock_i domain.
//  Drives the PHY's ctl_* command inputs and the DDR reset. Walks JEDEC init: RESET# hold, CKE delay, tXPR,
//  MRS MR2/MR3/MR1/MR0, ZQCL, tZQinit. Then asserts init_done_o so the main controller takes the command bus.
// PARAMETERS
//  BANK_BITS     3       bank address width
//  ROW_BITS      13      row bits; addr width = ROW_BITS+$clog2(DATA_BITS/8)
//  DATA_BITS     16      DQ width (address width only)
//  T_RESET       60000   cycles RESET# held low after reset release (200us)
//  T_CKE         150000  cycles from RESET# high to CKE high (500us)
//  T_XPR         120     cycles from CKE high to first MRS
//  T_MRD         4       MRS-to-MRS command spacing, cycles
//  T_MOD         12      MRS(MR0)-to-ZQCL spacing, cycles
//  T_ZQINIT      512     cycles from ZQCL to init_done_o
//  MR0/MR1/MR2/MR3  14'h1520/14'h0044/14'h0008/14'h0000  mode register values placed on addr
// PORTS
//  in_ddr_clock_i    in   1   DDR controller clock; same clock as the PHY command flops
//  in_phy_reset_i    in   1   async, active-high reset
//  restart_i         in   1   pulse: rerun full sequence; honoured only in DONE
//  ddr_reset_n_o     out  1   to PHY in_ddr_reset_n_i
//  ctl_cke_o         out  1   to PHY ctl_cke_i
//  ctl_cs_n_o        out  1   to PHY ctl_cs_n_i
//  ctl_ras_n_o       out  1   to PHY ctl_ras_n_i
//  ctl_cas_n_o       out  1   to PHY ctl_cas_n_i
//  ctl_we_n_o        out  1   to PHY ctl_we_n_i
//  ctl_odt_o         out  1   to PHY ctl_odt_i; constant 0
//  ctl_addr_o        out  ROW_BITS+$clog2(DATA_BITS/8)   to PHY ctl_addr_i
//  ctl_ba_o          out  BANK_BITS   to PHY ctl_ba_i
//  init_done_o       out  1   high = memory ready; level, held until reset/restart
// BEHAVIOUR
//  Reset values: ddr_reset_n_o=0, cke=0, cs_n=ras_n=cas_n=we_n=1, addr=0, ba=0, odt=0, init_done_o=0.
//  Async reset mid-sequence forces these values at once. Sequence restarts at RST_HOLD on release.
//  All outputs are registered. Cycle 0 = first rising edge with in_phy_reset_i low.
//  FSM: RST_HOLD -(T_RESET)-> CKE_WAIT -(T_CKE)-> XPR_WAIT -(T_XPR)-> MRS2 -(T_MRD)-> MRS3 -(T_MRD)-> MRS1
//       -(T_MRD)-> MRS0 -(T_MOD)-> ZQCL -(T_ZQINIT)-> DONE.
//   * RST_HOLD: ddr_reset_n_o rises at cycle T_RESET.
//   * CKE_WAIT: cke rises T_CKE cycles after ddr_reset_n_o.
//   * XPR_WAIT: first MRS issued T_XPR cycles after cke rises.
//  Spacing is edge-to-edge between command-issue cycles; e.g. MR3 is issued exactly T_MRD cycles after MR2.
//  Each command is exactly one cycle; all other cycles after CKE high are NOP.
//  Command encodings:
//   * NOP: cs0 ras1 cas1 we1.
//   * MRS: cs0 ras0 cas0 we0; ba=MR index (2,3,1,0); addr=MRn.
//   * ZQCL: cs0 ras1 cas1 we0; addr[10]=1, other addr bits=0, ba=0.
//  Before CKE high: cs_n=1 (deselect).
//  Outside command cycles: addr/ba=0.
//  init_done_o rises T_ZQINIT cycles after the ZQCL cycle. DONE outputs NOP with cke=1.
//  restart_i in DONE:
//   * next cycle init_done_o=0, cke=0, ddr_reset_n_o=0, cs_n=1; re-enter RST_HOLD.
//   * Full timing applies from that edge.
//  restart_i in any other state: ignored, no effect.
//  Single wait counter, width $clog2(max(T_*)+1). It is loaded with (T_x-1) on state entry and steps on zero.
//  All T_* >= 1, enforced by an elaboration-time $error.
// STRUCTURE
//  sddr_pkg: init_state_e enum; ddr_cmd_t struct {cs_n,ras_n,cas_n,we_n}; CMD_NOP/CMD_MRS/CMD_ZQCL/CMD_DESEL constants.
//  Sub-module sddr_wait_timer: loadable down-counter with zero flag; one instance.
// TESTING (T_RESET=10 T_CKE=20 T_XPR=5 T_MRD=4 T_MOD=12 T_ZQINIT=16)
//  1. Release reset at cycle 0 -> ddr_reset_n_o=1 @10; cke=1 @30; MRS ba=2 @35, ba=3 @39, ba=1 @43,
//     ba=0 @47; ZQCL @59; init_done_o=1 @75.
//  2. Every MRS/ZQCL lasts 1 cycle; cycles 30-74 otherwise NOP; addr=MRn on MRS; addr=14'h0400 on ZQCL.
//  3. Assert reset at cycle 41 (mid-MRS) -> outputs return to reset values the same cycle.
//     Release -> sequence 1 repeats from the new cycle 0.
//  4. restart_i pulse at cycle 80 (DONE) -> init_done_o=0, cke=0, reset_n=0 @81; MR2 re-issued @81+35=116.
//  5. restart_i pulse at cycle 20 (CKE_WAIT) -> ignored; timeline identical to scenario 1.
//  6. ctl_odt_o sampled every cycle of scenarios 1-5 -> always 0.

Source files
------------

// File: rtl/sddr_pkg.sv
// Shared types and constants for the DDR3 initialisation sequencer.
// State codes are plain constants so that legacy code can still compare against them.
package sddr_pkg;

    typedef logic [3:0] init_state_e;

    localparam init_state_e ST_RST_HOLD = 4'd0;
    localparam init_state_e ST_CKE_WAIT = 4'd1;
    localparam init_state_e ST_XPR_WAIT = 4'd2;
    localparam init_state_e ST_MRS2     = 4'd3;
    localparam init_state_e ST_MRS3     = 4'd4;
    localparam init_state_e ST_MRS1     = 4'd5;
    localparam init_state_e ST_MRS0     = 4'd6;
    localparam init_state_e ST_ZQCL     = 4'd7;
    localparam init_state_e ST_DONE     = 4'd8;

    typedef struct packed {
        logic cs_n;
        logic ras_n;
        logic cas_n;
        logic we_n;
    } ddr_cmd_t;

    localparam ddr_cmd_t CMD_NOP   = '{cs_n: 1'b0, ras_n: 1'b1, cas_n: 1'b1, we_n: 1'b1};
    localparam ddr_cmd_t CMD_MRS   = '{cs_n: 1'b0, ras_n: 1'b0, cas_n: 1'b0, we_n: 1'b0};
    localparam ddr_cmd_t CMD_ZQCL  = '{cs_n: 1'b0, ras_n: 1'b1, cas_n: 1'b1, we_n: 1'b0};
    localparam ddr_cmd_t CMD_DESEL = '{cs_n: 1'b1, ras_n: 1'b1, cas_n: 1'b1, we_n: 1'b1};

    function automatic int unsigned max_of6(input int unsigned a, input int unsigned b,
                                            input int unsigned c, input int unsigned d,
                                            input int unsigned e, input int unsigned f);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        if (e > m) m = e;
        if (f > m) m = f;
        return m;
    endfunction

endpackage

// File: rtl/sddr_wait_timer.sv
// Loadable down-counter with a zero flag; holds at zero until reloaded.
module sddr_wait_timer #(
    parameter int unsigned      WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= RESET_VALUE;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/sddr_init_seq.sv
// DDR3 power-up sequencer: RESET# hold, CKE delay, tXPR, MR2/MR3/MR1/MR0, ZQCL, tZQinit,
// then hands the command bus over by raising init_done_o.
module sddr_init_seq
    import sddr_pkg::*;
#(
    parameter int unsigned BANK_BITS = 3,
    parameter int unsigned ROW_BITS  = 13,
    parameter int unsigned DATA_BITS = 16,
    parameter int unsigned T_RESET   = 60000,
    parameter int unsigned T_CKE     = 150000,
    parameter int unsigned T_XPR     = 120,
    parameter int unsigned T_MRD     = 4,
    parameter int unsigned T_MOD     = 12,
    parameter int unsigned T_ZQINIT  = 512,
    parameter logic [13:0] MR0       = 14'h1520,
    parameter logic [13:0] MR1       = 14'h0044,
    parameter logic [13:0] MR2       = 14'h0008,
    parameter logic [13:0] MR3       = 14'h0000,
    localparam int unsigned ADDR_W   = ROW_BITS + $clog2(DATA_BITS / 8)
) (
    input  logic                 in_ddr_clock_i,
    input  logic                 in_phy_reset_i,
    input  logic                 restart_i,
    output logic                 ddr_reset_n_o,
    output logic                 ctl_cke_o,
    output logic                 ctl_cs_n_o,
    output logic                 ctl_ras_n_o,
    output logic                 ctl_cas_n_o,
    output logic                 ctl_we_n_o,
    output logic                 ctl_odt_o,
    output logic [ADDR_W-1:0]    ctl_addr_o,
    output logic [BANK_BITS-1:0] ctl_ba_o,
    output logic                 init_done_o
);

    localparam int unsigned CW = $clog2(max_of6(T_RESET, T_CKE, T_XPR, T_MRD, T_MOD, T_ZQINIT) + 1);

    localparam logic [CW-1:0] LD_RESET  = CW'(T_RESET - 1);
    localparam logic [CW-1:0] LD_CKE    = CW'(T_CKE - 1);
    localparam logic [CW-1:0] LD_XPR    = CW'(T_XPR - 1);
    localparam logic [CW-1:0] LD_MRD    = CW'(T_MRD - 1);
    localparam logic [CW-1:0] LD_MOD    = CW'(T_MOD - 1);
    localparam logic [CW-1:0] LD_ZQINIT = CW'(T_ZQINIT - 1);

    localparam logic [ADDR_W-1:0] ZQ_ADDR = ADDR_W'(1) << 10;

    if (T_RESET == 0 || T_CKE == 0 || T_XPR == 0 || T_MRD == 0 || T_MOD == 0 || T_ZQINIT == 0) begin : g_bad_timing
        $error("sddr_init_seq: every T_* parameter must be at least 1");
    end

    init_state_e      state;
    init_state_e      state_nxt;
    logic             entry;
    logic             load;
    logic [CW-1:0]    load_value;
    logic             zero;
    logic             cke_on;
    ddr_cmd_t         cmd;

    sddr_wait_timer #(
        .WIDTH      (CW),
        .RESET_VALUE(LD_RESET)
    ) u_timer (
        .clk       (in_ddr_clock_i),
        .rst       (in_phy_reset_i),
        .load      (load),
        .load_value(load_value),
        .zero      (zero)
    );

    always_comb begin
        state_nxt  = state;
        load       = 1'b0;
        load_value = '0;
        case (state)
            ST_RST_HOLD: if (zero) begin state_nxt = ST_CKE_WAIT; load = 1'b1; load_value = LD_CKE;    end
            ST_CKE_WAIT: if (zero) begin state_nxt = ST_XPR_WAIT; load = 1'b1; load_value = LD_XPR;    end
            ST_XPR_WAIT: if (zero) begin state_nxt = ST_MRS2;     load = 1'b1; load_value = LD_MRD;    end
            ST_MRS2:     if (zero) begin state_nxt = ST_MRS3;     load = 1'b1; load_value = LD_MRD;    end
            ST_MRS3:     if (zero) begin state_nxt = ST_MRS1;     load = 1'b1; load_value = LD_MRD;    end
            ST_MRS1:     if (zero) begin state_nxt = ST_MRS0;     load = 1'b1; load_value = LD_MOD;    end
            ST_MRS0:     if (zero) begin state_nxt = ST_ZQCL;     load = 1'b1; load_value = LD_ZQINIT; end
            ST_ZQCL:     if (zero) begin state_nxt = ST_DONE;                                          end
            ST_DONE:     if (restart_i) begin state_nxt = ST_RST_HOLD; load = 1'b1; load_value = LD_RESET; end
            default: begin
                state_nxt  = ST_RST_HOLD;
                load       = 1'b1;
                load_value = LD_RESET;
            end
        endcase
    end

    always_ff @(posedge in_ddr_clock_i or posedge in_phy_reset_i) begin
        if (in_phy_reset_i) begin
            state <= ST_RST_HOLD;
            entry <= 1'b0;
        end else begin
            state <= state_nxt;
            entry <= (state_nxt != state);
        end
    end

    assign cke_on = (state != ST_RST_HOLD) && (state != ST_CKE_WAIT);

    // Outputs are registered from the current state, so each visible edge lands one cycle
    // after the state change; this lag absorbs the (T-1) counter load.
    always_ff @(posedge in_ddr_clock_i or posedge in_phy_reset_i) begin
        if (in_phy_reset_i) begin
            ddr_reset_n_o <= 1'b0;
            ctl_cke_o     <= 1'b0;
            cmd           <= CMD_DESEL;
            ctl_addr_o    <= '0;
            ctl_ba_o      <= '0;
            init_done_o   <= 1'b0;
        end else begin
            ddr_reset_n_o <= (state != ST_RST_HOLD);
            ctl_cke_o     <= cke_on;
            cmd           <= cke_on ? CMD_NOP : CMD_DESEL;
            ctl_addr_o    <= '0;
            ctl_ba_o      <= '0;
            init_done_o   <= (state == ST_DONE);
            if (entry) begin
                case (state)
                    ST_MRS2: begin cmd <= CMD_MRS;  ctl_ba_o <= BANK_BITS'(2); ctl_addr_o <= ADDR_W'(MR2); end
                    ST_MRS3: begin cmd <= CMD_MRS;  ctl_ba_o <= BANK_BITS'(3); ctl_addr_o <= ADDR_W'(MR3); end
                    ST_MRS1: begin cmd <= CMD_MRS;  ctl_ba_o <= BANK_BITS'(1); ctl_addr_o <= ADDR_W'(MR1); end
                    ST_MRS0: begin cmd <= CMD_MRS;  ctl_ba_o <= BANK_BITS'(0); ctl_addr_o <= ADDR_W'(MR0); end
                    ST_ZQCL: begin cmd <= CMD_ZQCL; ctl_addr_o <= ZQ_ADDR; end
                    default: ;
                endcase
            end
        end
    end

    assign ctl_cs_n_o  = cmd.cs_n;
    assign ctl_ras_n_o = cmd.ras_n;
    assign ctl_cas_n_o = cmd.cas_n;
    assign ctl_we_n_o  = cmd.we_n;
    assign ctl_odt_o   = 1'b0;

endmodule

// File: tb/tb_sddr_init_seq.sv
// Scoreboard bench for sddr_init_seq with shortened timing; the expected bus per cycle
// is derived from the command timeline, not from the state machine.
module tb_sddr_init_seq;

    localparam int TR    = 10;
    localparam int TC    = 20;
    localparam int TX    = 5;
    localparam int TM    = 4;
    localparam int TMOD  = 12;
    localparam int TZQ   = 16;

    localparam int CKE_C  = TR + TC;
    localparam int MR2_C  = CKE_C + TX;
    localparam int MR3_C  = MR2_C + TM;
    localparam int MR1_C  = MR3_C + TM;
    localparam int MR0_C  = MR1_C + TM;
    localparam int ZQ_C   = MR0_C + TMOD;
    localparam int DONE_C = ZQ_C + TZQ;

    // {reset_n, cke, cs_n, ras_n, cas_n, we_n, odt, done, ba[2:0], addr[13:0]}
    localparam logic [24:0] RST_VEC = {1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 14'h0000};

    logic        clk = 1'b0;
    logic        rst;
    logic        restart;
    logic        ddr_reset_n;
    logic        cke, cs_n, ras_n, cas_n, we_n, odt;
    logic [13:0] addr;
    logic [2:0]  ba;
    logic        done;

    logic [24:0] exp_q[$];
    int          seq_cyc;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    sddr_init_seq #(
        .BANK_BITS(3),
        .ROW_BITS (13),
        .DATA_BITS(16),
        .T_RESET  (TR),
        .T_CKE    (TC),
        .T_XPR    (TX),
        .T_MRD    (TM),
        .T_MOD    (TMOD),
        .T_ZQINIT (TZQ)
    ) dut (
        .in_ddr_clock_i(clk),
        .in_phy_reset_i(rst),
        .restart_i     (restart),
        .ddr_reset_n_o (ddr_reset_n),
        .ctl_cke_o     (cke),
        .ctl_cs_n_o    (cs_n),
        .ctl_ras_n_o   (ras_n),
        .ctl_cas_n_o   (cas_n),
        .ctl_we_n_o    (we_n),
        .ctl_odt_o     (odt),
        .ctl_addr_o    (addr),
        .ctl_ba_o      (ba),
        .init_done_o   (done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [24:0] observed();
        return {ddr_reset_n, cke, cs_n, ras_n, cas_n, we_n, odt, done, ba, addr};
    endfunction

    function automatic logic [24:0] exp_at(input int c);
        logic        rn, ck, cs, ras, cas, we, dn;
        logic [2:0]  b;
        logic [13:0] a;
        rn  = (c >= TR);
        ck  = (c >= CKE_C);
        cs  = !ck;
        ras = 1'b1; cas = 1'b1; we = 1'b1;
        dn  = (c >= DONE_C);
        b   = 3'd0;
        a   = 14'h0000;
        if (c == MR2_C)      begin cs = 0; ras = 0; cas = 0; we = 0; b = 3'd2; a = 14'h0008; end
        else if (c == MR3_C) begin cs = 0; ras = 0; cas = 0; we = 0; b = 3'd3; a = 14'h0000; end
        else if (c == MR1_C) begin cs = 0; ras = 0; cas = 0; we = 0; b = 3'd1; a = 14'h0044; end
        else if (c == MR0_C) begin cs = 0; ras = 0; cas = 0; we = 0; b = 3'd0; a = 14'h1520; end
        else if (c == ZQ_C)  begin cs = 0; we = 0; a = 14'h0400; end
        return {rn, ck, cs, ras, cas, we, 1'b0, dn, b, a};
    endfunction

    // One clock: drive restart, predict the bus after the edge, compare at the falling edge.
    task automatic step(input bit rs);
        int c;
        restart = rs;
        @(posedge clk);
        c = seq_cyc;
        exp_q.push_back(exp_at(c));
        if (rs && c > DONE_C) seq_cyc = 0;
        else                  seq_cyc++;
        @(negedge clk);
        restart = 1'b0;
        check($sformatf("bus@%0d", c), 32'(observed()), 32'(exp_q.pop_front()));
        check($sformatf("odt@%0d", c), 32'(odt), 32'd0);
    endtask

    initial begin
        rst     = 1'b1;
        restart = 1'b0;
        seq_cyc = 0;
        repeat (3) @(negedge clk);
        check("reset_values", 32'(observed()), 32'(RST_VEC));
        rst = 1'b0;

        // Full sequence, then a restart pulse in DONE at cycle 80.
        repeat (80) step(1'b0);
        step(1'b1);
        check("restart_seq_zero", 32'(seq_cyc), 32'd0);

        // Restarted sequence with an ignored pulse in CKE_WAIT at cycle 20.
        repeat (20) step(1'b0);
        step(1'b1);
        repeat (DONE_C + 5 - 21) step(1'b0);

        // Fresh sequence, async reset mid-MRS after cycle 41.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        seq_cyc = 0;
        repeat (42) step(1'b0);
        rst = 1'b1;
        #1;
        check("async_reset", 32'(observed()), 32'(RST_VEC));
        repeat (2) @(negedge clk);
        check("reset_held", 32'(observed()), 32'(RST_VEC));
        rst = 1'b0;
        seq_cyc = 0;
        repeat (DONE_C + 3) step(1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
